// File: rtl/i2c_nco_master.sv
// I2C write-only master that sends one NCO configuration frame per accepted start:
// address byte, control byte, then 0/2/8 data bytes, with quarter-period bit timing.
module i2c_nco_master #(
    parameter logic [6:0]  ADDRESS = 7'b1101010,
    parameter int unsigned CLK_DIV = 250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        enable_in,
    input  logic [1:0]  wave_in,
    input  logic [63:0] frequency_in,
    input  logic [15:0] duty_in,
    output wire         scl,
    inout  wire         sda,
    output logic        busy,
    output logic        done,
    output logic        nack
);

    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StCtrl,
        StData,
        StAck,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      byte_q, byte_d;
    logic [7:0]      ctrl_q, ctrl_d;
    logic [63:0]     data_q, data_d;
    logic [3:0]      left_q, left_d;
    logic            after_addr_q, after_addr_d;
    logic            nack_q, nack_d;
    logic            done_q, done_d;
    logic            scl_low_q, scl_low_d;
    logic            sda_low_q, sda_low_d;

    logic sda_in;
    logic quarter_end;
    logic bit_end;

    assign sda_in      = sda;
    assign quarter_end = (div_q == DivLast);
    assign bit_end     = quarter_end && (quarter_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            div_q        <= '0;
            quarter_q    <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            ctrl_q       <= '0;
            data_q       <= '0;
            left_q       <= '0;
            after_addr_q <= 1'b0;
            nack_q       <= 1'b0;
            done_q       <= 1'b0;
            scl_low_q    <= 1'b0;
            sda_low_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            quarter_q    <= quarter_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            left_q       <= left_d;
            after_addr_q <= after_addr_d;
            nack_q       <= nack_d;
            done_q       <= done_d;
            scl_low_q    <= scl_low_d;
            sda_low_q    <= sda_low_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        quarter_d    = quarter_q;
        bit_d        = bit_q;
        byte_d       = byte_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        left_d       = left_q;
        after_addr_d = after_addr_q;
        nack_d       = nack_q;
        done_d       = 1'b0;

        if (state_q != StIdle) begin
            if (quarter_end) begin
                div_d     = '0;
                quarter_d = quarter_q + 2'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StStart;
                    div_d     = '0;
                    quarter_d = '0;
                    bit_d     = '0;
                    byte_d    = {ADDRESS, 1'b0};
                    ctrl_d    = {3'b000, mode == 2'b10, mode == 2'b01, wave_in, enable_in};
                    // Duty is left-aligned so both data kinds shift out from the top byte.
                    data_d    = (mode == 2'b10) ? {duty_in, 48'h0} : frequency_in;
                    left_d    = (mode == 2'b01) ? 4'd8 : (mode == 2'b10) ? 4'd2 : 4'd0;
                    nack_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StAddr;
                end
            end
            StAddr, StCtrl, StData: begin
                if (bit_end) begin
                    byte_d = {byte_q[6:0], 1'b0};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d      = StAck;
                        after_addr_d = (state_q == StAddr);
                    end
                end
            end
            StAck: begin
                if (quarter_q == 2'd2 && quarter_end) begin
                    nack_d = sda_in;
                end
                if (bit_end) begin
                    if (nack_q) begin
                        state_d = StStop;
                    end else if (after_addr_q) begin
                        state_d = StCtrl;
                        byte_d  = ctrl_q;
                    end else if (left_q != 4'd0) begin
                        state_d = StData;
                        byte_d  = data_q[63:56];
                        data_d  = {data_q[55:0], 8'h00};
                        left_d  = left_q - 4'd1;
                    end else begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line drives are decoded from next-state so the registered pins line up with state_q.
    always_comb begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_d)
            StStart: sda_low_d = quarter_d[1];
            StAddr, StCtrl, StData: begin
                scl_low_d = !quarter_d[1];
                sda_low_d = !byte_d[7];
            end
            StAck:  scl_low_d = !quarter_d[1];
            StStop: begin
                scl_low_d = (quarter_d == 2'd0);
                sda_low_d = !quarter_d[1];
            end
            default: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
        endcase
    end

    assign scl  = scl_low_q ? 1'b0 : 1'bz;
    assign sda  = sda_low_q ? 1'b0 : 1'bz;
    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign nack = nack_q;

endmodule

// File: tb/tb_i2c_nco_master.sv
// Bench for i2c_nco_master: a behavioural I2C slave feeds a byte scoreboard, and a done
// monitor checks frame length and nack against a frame-level reference model.
module tb_i2c_nco_master;

    localparam int          D    = 4;
    localparam logic [6:0]  ADDR = 7'b1101010;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        enable_in = 1'b0;
    logic [1:0]  wave_in = 2'b00;
    logic [63:0] frequency_in = 64'h0;
    logic [15:0] duty_in = 16'h0;
    wire         scl;
    wire         sda;
    logic        busy;
    logic        done;
    logic        nack;

    pullup (scl);
    pullup (sda);

    i2c_nco_master #(
        .ADDRESS (ADDR),
        .CLK_DIV (D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .mode         (mode),
        .enable_in    (enable_in),
        .wave_in      (wave_in),
        .frequency_in (frequency_in),
        .duty_in      (duty_in),
        .scl          (scl),
        .sda          (sda),
        .busy         (busy),
        .done         (done),
        .nack         (nack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit nack;
        int nbytes;
    } frame_t;

    frame_t      exp_frames[$];
    logic [7:0]  exp_bytes[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          rx_cnt = 0;
    logic [6:0]  slave_addr = ADDR;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Reference model: bytes on the wire, frame length in quarters, ack outcome.
    task automatic push_expect(input logic [1:0] m, input logic en, input logic [1:0] w,
                               input logic [63:0] f, input logic [15:0] dty);
        logic [7:0] b[$];
        frame_t     fr;
        bit         match;
        match = (slave_addr == ADDR);
        b.push_back({ADDR, 1'b0});
        if (match) begin
            b.push_back({3'b000, m == 2'd2, m == 2'd1, w, en});
            if (m == 2'd1) for (int i = 7; i >= 0; i--) b.push_back(f[i*8 +: 8]);
            if (m == 2'd2) begin
                b.push_back(dty[15:8]);
                b.push_back(dty[7:0]);
            end
        end
        fr.nbytes = b.size();
        fr.nack   = !match;
        fr.len    = match ? (4 + 36 * b.size() + 4) * D : (4 + 36 + 4) * D;
        exp_frames.push_back(fr);
        foreach (b[i]) exp_bytes.push_back(b[i]);
    endtask

    // Behavioural slave: decodes START/STOP and bytes, ACKs when addressed.
    logic       slave_low = 1'b0;
    logic       ps, pd;
    int         bitn;
    logic [7:0] sh;
    bit         first, addressed, in_frame;

    assign sda = slave_low ? 1'b0 : 1'bz;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_low = 1'b0;
            in_frame  = 1'b0;
            bitn      = 0;
            ps        = 1'b1;
            pd        = 1'b1;
        end else begin
            if (scl && ps && pd && !sda) begin
                in_frame  = 1'b1;
                bitn      = 0;
                first     = 1'b1;
                addressed = 1'b0;
            end else if (scl && ps && !pd && sda) begin
                in_frame = 1'b0;
            end else if (in_frame && scl && !ps) begin
                bitn++;
                if (bitn <= 8) sh = {sh[6:0], sda};
                if (bitn == 8) begin
                    if (exp_bytes.size() == 0) fail_now("byte_unexpected");
                    else check("byte", {56'h0, sh}, {56'h0, exp_bytes.pop_front()});
                    rx_cnt++;
                end
            end else if (in_frame && !scl && ps) begin
                if (bitn == 8) begin
                    if (first) begin
                        addressed = (sh[7:1] == slave_addr);
                        first     = 1'b0;
                    end
                    slave_low = addressed;
                end else if (bitn == 9) begin
                    slave_low = 1'b0;
                    bitn      = 0;
                end
            end
            ps = scl;
            pd = sda;
        end
    end

    // Frame monitor: checks each done pulse against the next expected frame.
    int   blen = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            blen      = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                frame_t fr;
                check("done_width", {63'h0, prev_done}, 64'h0);
                check("busy_at_done", {63'h0, busy}, 64'h0);
                if (exp_frames.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    fr = exp_frames.pop_front();
                    check("frame_len", blen, fr.len);
                    check("nack", {63'h0, nack}, {63'h0, fr.nack});
                    check("frame_bytes", rx_cnt, fr.nbytes);
                end
                rx_cnt = 0;
                blen   = 0;
            end else if (busy) begin
                blen++;
            end
            prev_done = done;
        end
    end

    task automatic wait_done();
        int t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!done) fail_now("done_timeout");
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] m, input logic en, input logic [1:0] w,
                        input logic [63:0] f, input logic [15:0] dty, input bit glitch);
        int t = 0;
        @(negedge clk);
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (busy) fail_now("idle_timeout");
        mode         = m;
        enable_in    = en;
        wave_in      = w;
        frequency_in = f;
        duty_in      = dty;
        push_expect(m, en, w, f, dty);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", {63'h0, busy}, 64'h1);
        check("nack_clear", {63'h0, nack}, 64'h0);
        if (glitch) begin
            repeat (98) @(negedge clk);
            mode         = ~m;
            enable_in    = ~en;
            wave_in      = ~w;
            frequency_in = {$urandom, $urandom};
            duty_in      = 16'($urandom);
            start        = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_nack", {63'h0, nack}, 64'h0);
        check("rst_scl", {63'h0, scl}, 64'h1);
        check("rst_sda", {63'h0, sda}, 64'h1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        send(2'd1, 1'b1, 2'd2, 64'h0123456789ABCDEF, 16'h0, 1'b0);
        send(2'd2, 1'b0, 2'd0, 64'h0, 16'h8000, 1'b0);
        send(2'd3, 1'b1, 2'd3, {$urandom, $urandom}, 16'($urandom), 1'b0);
        send(2'd0, 1'b0, 2'd1, 64'h0, 16'h0, 1'b0);

        slave_addr = 7'b0000001;
        send(2'd1, 1'b1, 2'd3, {$urandom, $urandom}, 16'h0, 1'b0);
        slave_addr = ADDR;
        send(2'd0, 1'b1, 2'd1, 64'h0, 16'h0, 1'b1);
        send(2'd1, 1'b0, 2'd2, {$urandom, $urandom}, 16'($urandom), 1'b1);

        // Start held high across done: the next frame begins right after busy falls.
        begin
            int t = 0;
            @(negedge clk);
            mode    = 2'd2;
            duty_in = 16'h1234;
            push_expect(2'd2, enable_in, wave_in, frequency_in, 16'h1234);
            start = 1'b1;
            @(negedge clk);
            while (!done && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (!done) fail_now("held_done_timeout");
            push_expect(2'd2, enable_in, wave_in, frequency_in, 16'h1234);
            @(negedge clk);
            check("back_to_back", {63'h0, busy}, 64'h1);
            start = 1'b0;
            wait_done();
        end

        // Reset mid-way through a frequency frame.
        @(negedge clk);
        mode         = 2'd1;
        frequency_in = {$urandom, $urandom};
        push_expect(2'd1, enable_in, wave_in, frequency_in, duty_in);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (298) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_scl", {63'h0, scl}, 64'h1);
        check("mid_rst_sda", {63'h0, sda}, 64'h1);
        check("mid_rst_busy", {63'h0, busy}, 64'h0);
        exp_bytes.delete();
        exp_frames.delete();
        rx_cnt = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        send(2'd1, 1'b1, 2'd1, {$urandom, $urandom}, 16'h0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            slave_addr = ($urandom_range(0, 4) == 0) ? 7'h01 : ADDR;
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 16'($urandom), 1'($urandom_range(0, 1)));
        end
        slave_addr = ADDR;

        repeat (20) @(negedge clk);
        check("frames_left", exp_frames.size(), 0);
        check("bytes_left", exp_bytes.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
